// File: rtl/vmem_seq_if.sv
// Command, store-data and mem_queue request/completion signals of the vector memory sequencer.
// The slave modport is the sequencer; the master modport is the decode/queue environment.
interface vmem_seq_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CNT_BITS   = 9
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_store;
   logic [ADDR_WIDTH-1:0] cmd_base;
   logic [ADDR_WIDTH-1:0] cmd_stride;
   logic [CNT_BITS-1:0]   cmd_count;
   logic [DATA_WIDTH-1:0] st_data;
   logic                  st_valid;
   logic                  st_ready;
   logic [ADDR_WIDTH-1:0] q_addr;
   logic                  q_req;
   logic                  q_valid;
   logic [DATA_WIDTH-1:0] q_data;
   logic                  q_ld_ready;
   logic                  q_done_ld;
   logic                  q_done_st;

   modport master (
      output cmd_valid, cmd_store, cmd_base, cmd_stride, cmd_count, st_data, st_valid,
             q_done_ld, q_done_st,
      input  cmd_ready, st_ready, q_addr, q_req, q_valid, q_data, q_ld_ready
   );

   modport slave (
      input  cmd_valid, cmd_store, cmd_base, cmd_stride, cmd_count, st_data, st_valid,
             q_done_ld, q_done_st,
      output cmd_ready, st_ready, q_addr, q_req, q_valid, q_data, q_ld_ready
   );
endinterface

// File: rtl/vmem_seq.sv
// Vector memory sequencer: expands one strided load/store command into per-element queue
// requests, waits for the queue's burst completion and retires with done (err on watchdog).
module vmem_seq #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned CNT_BITS       = 9,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic           clk,
   input  logic           rst_n,
   vmem_seq_if.slave      bus,
   output logic           busy_o,
   output logic           done_o,
   output logic           err_o
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   localparam logic [31:0] WdLast = 32'(TIMEOUT_CYCLES - 1);

   state_e                state_q, state_d;
   logic                  store_q, store_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [CNT_BITS-1:0]   rem_q, rem_d;
   logic [31:0]           wd_q, wd_d;
   logic                  err_q, err_d;
   logic                  wd_expire;
   logic                  completion;

   assign wd_expire  = (TIMEOUT_CYCLES != 0) && (wd_q == WdLast);
   assign completion = store_q ? bus.q_done_st : bus.q_done_ld;

   always_comb begin
      state_d        = state_q;
      store_d        = store_q;
      addr_d         = addr_q;
      stride_d       = stride_q;
      rem_d          = rem_q;
      wd_d           = '0;
      err_d          = err_q;
      bus.cmd_ready  = 1'b0;
      bus.st_ready   = 1'b0;
      bus.q_addr     = '0;
      bus.q_req      = 1'b0;
      bus.q_valid    = 1'b0;
      bus.q_data     = {DATA_WIDTH{1'b0}};
      bus.q_ld_ready = 1'b0;
      busy_o         = 1'b1;
      done_o         = 1'b0;
      err_o          = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy_o        = 1'b0;
            bus.cmd_ready = 1'b1;
            err_d         = 1'b0;
            if (bus.cmd_valid) begin
               store_d  = bus.cmd_store;
               addr_d   = bus.cmd_base;
               stride_d = bus.cmd_stride;
               rem_d    = bus.cmd_count;
               state_d  = (bus.cmd_count == '0) ? StDone : StIssue;
            end
         end
         StIssue: begin
            bus.q_addr = addr_q;
            if (store_q) begin
               bus.st_ready = 1'b1;
               bus.q_valid  = bus.st_valid;
               bus.q_data   = bus.st_data;
            end else begin
               bus.q_req = 1'b1;
            end
            // Loads advance every cycle; stores only on an accepted beat.
            if (!store_q || bus.st_valid) begin
               addr_d = addr_q + stride_q;
               rem_d  = rem_q - CNT_BITS'(1);
               if (rem_q == CNT_BITS'(1)) state_d = StWait;
            end
         end
         StWait: begin
            bus.q_ld_ready = !store_q;
            wd_d           = wd_q + 32'd1;
            // Completion takes priority over a coincident watchdog expiry.
            if (completion) begin
               state_d = StDone;
            end else if (wd_expire) begin
               state_d = StDone;
               err_d   = 1'b1;
            end
         end
         StDone: begin
            done_o  = 1'b1;
            err_o   = err_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         store_q  <= 1'b0;
         addr_q   <= '0;
         stride_q <= '0;
         rem_q    <= '0;
         wd_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         rem_q    <= rem_d;
         wd_q     <= wd_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_vmem_seq.sv
// Bench for vmem_seq: table of directed commands, random commands checked against an
// arithmetic element/latency model, and a mid-command reset sequence.
module tb_vmem_seq;

   logic clk = 1'b0;
   logic rst_n;
   logic busy, done, err;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vmem_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .CNT_BITS(9)) bus ();

   vmem_seq #(
      .ADDR_WIDTH(32), .DATA_WIDTH(64), .CNT_BITS(9), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy), .done_o(done), .err_o(err)
   );

   typedef struct {
      bit          store;
      logic [31:0] base;
      logic [31:0] stride;
      int          count;
      logic [31:0] gap_mask;  // bit c set: st_valid low on issue cycle c
      int          delay;     // WAIT cycle index of completion; >15 means never
      bit          exp_err;
      int          exp_lat;   // accept-to-done cycles, -1 if not checked
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Junk on inputs that must be ignored in the current state.
   task automatic noise();
      bus.cmd_valid  = 1'($urandom);
      bus.cmd_store  = 1'($urandom);
      bus.cmd_base   = $urandom;
      bus.cmd_stride = $urandom;
      bus.cmd_count  = 9'($urandom);
      bus.q_done_ld  = 1'($urandom);
      bus.q_done_st  = 1'($urandom);
      bus.st_valid   = 1'($urandom);
      bus.st_data    = {$urandom, $urandom};
   endtask

   task automatic quiet();
      bus.cmd_valid = 1'b0; bus.cmd_store = 1'b0; bus.cmd_base = '0; bus.cmd_stride = '0;
      bus.cmd_count = '0;   bus.q_done_ld = 1'b0; bus.q_done_st = 1'b0;
      bus.st_valid  = 1'b0; bus.st_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cmd(input vec_t v);
      int          t0, k, c, w;
      logic [31:0] exp_addr;
      bit          sv;
      step();
      quiet();
      bus.cmd_valid  = 1'b1;
      bus.cmd_store  = v.store;
      bus.cmd_base   = v.base;
      bus.cmd_stride = v.stride;
      bus.cmd_count  = 9'(v.count);
      #1;
      chk("idle_cmd_ready", bus.cmd_ready, 1);
      chk("idle_busy", busy, 0);
      t0 = cyc;
      k = 0;
      c = 0;
      while (k < v.count) begin
         step();
         noise();
         sv = (c < 32) ? !v.gap_mask[c] : 1'b1;
         if (v.store) bus.st_valid = sv;
         #1;
         exp_addr = v.base + 32'(k) * v.stride;
         chk("issue_addr", bus.q_addr, exp_addr);
         chk("issue_req", bus.q_req, !v.store);
         chk("issue_st_ready", bus.st_ready, v.store);
         chk("issue_valid", bus.q_valid, v.store && sv);
         if (v.store && sv) chk("issue_data", bus.q_data, bus.st_data);
         chk("issue_ctrl", {bus.cmd_ready, bus.q_ld_ready, done, busy}, 4'b0001);
         if (!v.store || sv) k++;
         c++;
         if (c > v.count + 64) begin
            chk("issue_bound", 0, 1);
            return;
         end
      end
      if (v.count != 0) begin
         w = 0;
         forever begin
            step();
            noise();
            if (v.store) bus.q_done_st = (w == v.delay);
            else         bus.q_done_ld = (w == v.delay);
            #1;
            chk("wait_ld_ready", bus.q_ld_ready, !v.store);
            chk("wait_quiet", {bus.q_req, bus.q_valid, bus.st_ready, done, bus.cmd_ready}, 0);
            chk("wait_addr", bus.q_addr, 0);
            if (w == v.delay || w == 15) break;
            w++;
         end
      end
      step();
      noise();
      #1;
      chk("done_pulse", done, 1);
      chk("done_err", err, v.exp_err);
      chk("done_cmd_ready", bus.cmd_ready, 0);
      chk("done_quiet", {bus.q_req, bus.q_valid, bus.q_ld_ready, bus.st_ready}, 0);
      if (v.exp_lat >= 0) chk("done_latency", 64'(cyc - t0), 64'(v.exp_lat));
      step();
      quiet();
      #1;
      chk("retire_idle", {bus.cmd_ready, busy, done, err}, 4'b1000);
   endtask

   initial begin
      vec_t vecs[10];
      vec_t rv;
      vecs[0] = '{0, 32'h1000, 32'h4, 4, 32'h0, 4, 0, 10};
      vecs[1] = '{1, 32'h2000, 32'h8, 3, 32'h2, 2, 0, 8};
      vecs[2] = '{0, 32'h4, 32'hFFFF_FFFC, 3, 32'h0, 0, 0, 5};
      vecs[3] = '{0, 32'h40, 32'h4, 0, 32'h0, 0, 0, 1};
      vecs[4] = '{1, 32'h40, 32'h4, 0, 32'h0, 0, 0, 1};
      vecs[5] = '{0, 32'h100, 32'h10, 2, 32'h0, 99, 1, 19};
      vecs[6] = '{0, 32'h100, 32'h10, 2, 32'h0, 15, 0, 19};
      vecs[7] = '{1, 32'h0, 32'h1, 1, 32'h0, 99, 1, 18};
      vecs[8] = '{1, 32'h0, 32'h1, 1, 32'h0, 15, 0, 18};
      vecs[9] = '{0, 32'h8000_0000, 32'h1, 511, 32'h0, 0, 0, 513};

      quiet();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("reset_outputs", {bus.cmd_ready, busy, done, err, bus.q_req, bus.q_valid,
                            bus.q_ld_ready, bus.st_ready}, 8'b1000_0000);
      chk("reset_addr", bus.q_addr, 0);
      chk("reset_data", bus.q_data, 0);

      foreach (vecs[i]) run_cmd(vecs[i]);

      for (int i = 0; i < 40; i++) begin
         rv.store    = 1'($urandom);
         rv.base     = $urandom;
         rv.stride   = (i % 2 == 0) ? $urandom : 32'($signed(32'($urandom_range(0, 16))) - 8);
         rv.count    = $urandom_range(0, 20);
         rv.gap_mask = $urandom;
         rv.delay    = $urandom_range(0, 20);
         rv.exp_err  = (rv.count != 0) && (rv.delay > 15);
         rv.exp_lat  = -1;
         run_cmd(rv);
      end

      // Reset for one cycle in the middle of a load: command dropped, no done.
      step();
      quiet();
      bus.cmd_valid  = 1'b1;
      bus.cmd_base   = 32'h3000;
      bus.cmd_stride = 32'h4;
      bus.cmd_count  = 9'd8;
      step();
      quiet();
      #1;
      chk("rst_seq_issue", bus.q_req, 1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("rst_seq_outputs", {bus.cmd_ready, busy, done, err, bus.q_req, bus.q_valid,
                              bus.q_ld_ready, bus.st_ready}, 8'b1000_0000);
      chk("rst_seq_addr", bus.q_addr, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         #1;
         chk("rst_seq_no_done", {done, busy}, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "time limit");
   end

endmodule
